// File: rtl/seg_reader_pkg.sv
// rtl/seg_reader_pkg.sv - shared glyph constants, sizes and FSM state type for seg_reader
package seg_reader_pkg;

  localparam int SEG_W  = 7;
  localparam int DIGITS = 4;

  localparam logic [SEG_W-1:0] BLANK   = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0001100;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b1100000;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b0110001;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b1000010;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b0111000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  // True when exactly one anode line is driven low.
  function automatic logic onehot_low(input logic [DIGITS-1:0] a);
    logic [DIGITS-1:0] n;
    n = ~a;
    return (n != '0) && ((n & (n - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seg_reader_glyph.sv
// rtl/seg_reader_glyph.sv - combinational 7-segment pattern to hex nibble lookup
module seg_glyph_decode
  import seg_reader_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             illegal
);

  // Table lookup; anything outside the sixteen glyphs reads as 0 and is flagged.
  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b0;
    case (pattern)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_reader.sv
// rtl/seg_reader.sv - recovers a 4-digit hex frame from a multiplexed 7-segment display bus
module seg_reader
  import seg_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIGITS-1:0] an,
  input  logic [SEG_W-1:0]  LED,
  output logic [15:0]       value,
  output logic [DIGITS-1:0] digit_err,
  output logic              valid,
  input  logic              ready,
  output logic              overrun
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [DIGITS-1:0] an_q, an_p;
  logic [SEG_W-1:0]  led_q, led_p;
  state_t            state, next_state;
  logic [7:0]        cnt, next_cnt;
  logic              capture;
  logic [DIGITS-1:0] seen;
  logic [15:0]       slot_val;
  logic [DIGITS-1:0] slot_err;
  logic [3:0]        dec_nibble;
  logic              dec_illegal;
  logic              an_ok, an_same, sample_same;
  logic              frame_done, handshake;
  logic [DIGITS-1:0] sel;

  seg_glyph_decode u_decode (
    .pattern (led_q),
    .nibble  (dec_nibble),
    .illegal (dec_illegal)
  );

  assign an_ok       = onehot_low(an_q);
  assign an_same     = (an_q == an_p);
  assign sample_same = an_same && (led_q == led_p);
  assign sel         = ~an_q;
  assign frame_done  = (seen == {DIGITS{1'b1}});
  assign handshake   = valid && ready;

  // Input sample register plus one-sample history used for change detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      an_q  <= {DIGITS{1'b1}};
      an_p  <= {DIGITS{1'b1}};
      led_q <= BLANK;
      led_p <= BLANK;
    end else begin
      an_q  <= an;
      an_p  <= an_q;
      led_q <= LED;
      led_p <= led_q;
    end
  end

  // FSM state and stability counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic: a digit is captured on the cycle its count reaches the threshold.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (an_ok) begin
          next_state = ST_SETTLE;
          next_cnt   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!an_ok) begin
          next_state = ST_IDLE;
          next_cnt   = 8'd0;
        end else if (!sample_same) begin
          next_cnt = 8'd1;
        end else begin
          next_cnt = cnt + 8'd1;
        end
      end
      ST_HELD: begin
        if (!an_same) begin
          if (an_ok) begin
            next_state = ST_SETTLE;
            next_cnt   = 8'd1;
          end else begin
            next_state = ST_IDLE;
            next_cnt   = 8'd0;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = 8'd0;
      end
    endcase
    if (next_state == ST_SETTLE && next_cnt == STABLE_N) begin
      capture    = 1'b1;
      next_state = ST_HELD;
    end
  end

  // Working slots and seen marks; a recapture overwrites, completion clears the marks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seen     <= '0;
      slot_val <= 16'h0000;
      slot_err <= '0;
    end else begin
      seen <= (frame_done ? {DIGITS{1'b0}} : seen) | (capture ? sel : {DIGITS{1'b0}});
      for (int k = 0; k < DIGITS; k++) begin
        if (capture && sel[k]) begin
          slot_val[4*k +: 4] <= dec_nibble;
          slot_err[k]        <= dec_illegal;
        end
      end
    end
  end

  // Output frame with valid/ready hold, drop-on-busy and sticky overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value     <= 16'h0000;
      digit_err <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_done && (!valid || handshake)) begin
        value     <= slot_val;
        digit_err <= slot_err;
        valid     <= 1'b1;
      end else if (handshake) begin
        valid <= 1'b0;
      end
      if (frame_done && valid && !ready) begin
        overrun <= 1'b1;
      end else if (handshake) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_reader.sv
// tb/tb_seg_reader.sv - scoreboard bench for seg_reader
module tb_seg_reader;

  logic        clk;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  LED;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        valid;
  logic        ready;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int hs_before;
  int lat;

  logic [15:0] sb_val[$];
  logic [3:0]  sb_err[$];

  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] G [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg_reader #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .an        (an),
    .LED       (LED),
    .value     (value),
    .digit_err (digit_err),
    .valid     (valid),
    .ready     (ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic [3:0] e);
    sb_val.push_back(v);
    sb_err.push_back(e);
  endtask

  task automatic show(input int k, input logic [6:0] pat, input int n);
    an  = ~(4'b0001 << k);
    LED = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_raw(input logic [3:0] a, input logic [6:0] pat, input int n);
    an  = a;
    LED = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted frame is compared with the oldest expected one.
  always @(negedge clk) begin
    if (reset && valid && ready) begin
      hs_count++;
      if (sb_val.size() == 0) begin
        check("unexpected_frame", {16'h0, value}, 32'hFFFF_FFFF);
      end else begin
        check("frame_value", {16'h0, value}, {16'h0, sb_val.pop_front()});
        check("frame_err", {28'h0, digit_err}, {28'h0, sb_err.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b0;
    an    = 4'hF;
    LED   = BLK;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", {16'h0, value}, 32'h0);
    check("rst_err", {28'h0, digit_err}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    reset = 1'b1;
    drive_raw(4'hF, BLK, 2);

    // Basic scan 4,3,2,1 on digits 0..3.
    hs_before = hs_count;
    expect_frame(16'h1234, 4'h0);
    show(0, G[4], 8);
    show(1, G[3], 8);
    show(2, G[2], 8);
    show(3, G[1], 8);
    drive_raw(4'hF, BLK, 4);
    check("t1_pulses", hs_count - hs_before, 1);

    // Blank digit 2 decodes as 0 with its error bit set.
    expect_frame(16'hF0FF, 4'b0100);
    show(0, G[15], 8);
    show(1, G[15], 8);
    show(2, BLK, 8);
    show(3, G[15], 8);
    drive_raw(4'hF, BLK, 4);

    // Digit 0 toggling every 3 clocks never settles.
    hs_before = hs_count;
    for (int i = 0; i < 10; i++) show(0, (i % 2 == 0) ? G[1] : G[2], 3);
    drive_raw(4'hF, BLK, 4);
    check("t3_pulses", hs_count - hs_before, 0);
    check("t3_valid", {31'h0, valid}, 32'h0);

    // Two scans with ready low: second frame is dropped, overrun sticks.
    ready = 1'b0;
    show(0, G[13], 8);
    show(1, G[12], 8);
    show(2, G[11], 8);
    show(3, G[10], 8);
    drive_raw(4'hF, BLK, 2);
    check("t4_valid_first", {31'h0, valid}, 32'h1);
    check("t4_overrun_first", {31'h0, overrun}, 32'h0);
    for (int k = 0; k < 4; k++) show(k, G[0], 8);
    drive_raw(4'hF, BLK, 2);
    check("t4_value_held", {16'h0, value}, 32'h0000_ABCD);
    check("t4_overrun", {31'h0, overrun}, 32'h1);
    check("t4_valid_held", {31'h0, valid}, 32'h1);
    expect_frame(16'hABCD, 4'h0);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_valid_after", {31'h0, valid}, 32'h0);
    check("t4_overrun_after", {31'h0, overrun}, 32'h0);
    drive_raw(4'hF, BLK, 2);

    // Non-one-hot anodes between digits; digit 1 recaptured keeps latest value.
    hs_before = hs_count;
    expect_frame(16'h9E70, 4'h0);
    show(0, G[0], 8);
    drive_raw(4'b1100, G[5], 4);
    show(1, G[3], 8);
    drive_raw(4'hF, BLK, 3);
    show(2, G[14], 8);
    drive_raw(4'b1100, G[2], 3);
    show(1, G[7], 8);
    check("t5_early_valid", {31'h0, valid}, 32'h0);
    check("t5_early_pulses", hs_count - hs_before, 0);
    show(3, G[9], 8);
    drive_raw(4'hF, BLK, 4);
    check("t5_pulses", hs_count - hs_before, 1);

    // Reset during SETTLE of the third digit, then a reversed-order scan.
    show(0, G[1], 8);
    show(1, G[2], 8);
    show(2, G[6], 3);
    an = 4'hF;
    LED = BLK;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("t6_value", {16'h0, value}, 32'h0);
    check("t6_err", {28'h0, digit_err}, 32'h0);
    check("t6_valid", {31'h0, valid}, 32'h0);
    check("t6_overrun", {31'h0, overrun}, 32'h0);
    drive_raw(4'hF, BLK, 2);
    expect_frame(16'h5678, 4'h0);
    show(3, G[5], 8);
    show(2, G[6], 8);
    show(1, G[7], 8);
    an  = 4'b1110;
    LED = G[8];
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!valid && lat < 20);
    check("latency", lat, 6);
    drive_raw(4'b1110, G[8], 4);
    drive_raw(4'hF, BLK, 4);

    check("sb_drained", sb_val.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples that count as a settled digit; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 an  input  4  active-low digit anodes; an[k]=0 selects digit k (k=0 is least significant).
REQ-005 LED  input  7  active-low segments, bit6..bit0 = a,b,c,d,e,f,g (the team's 7-segment encoding).
REQ-006 value  output  16  recovered hex frame; digit k occupies value[4k+3:4k].
REQ-007 digit_err  output  4  per-digit flag, bit k set when digit k's settled pattern was not a legal glyph.
REQ-008 valid  output  1  frame available; value and digit_err are stable while valid=1.
REQ-009 ready  input  1  consumer accepts the frame on any cycle where valid=1 and ready=1.
REQ-010 overrun  output  1  sticky flag: at least one completed frame was dropped while valid=1 waited for ready.

Function
REQ-011 Legal glyph table, pattern->nibble: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0001100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F.
REQ-012 Any other pattern, including blank 1111111, shall decode to nibble 0 and set that digit's error bit.
REQ-013 The inputs an and LED shall be registered once before use; all latencies below count from that registered sample.
REQ-014 Sample FSM states: IDLE, SETTLE, HELD.
REQ-015 IDLE: when the sampled an is one-hot-low, the FSM shall load the stability counter with 1 and enter SETTLE.
REQ-016 SETTLE: if an or LED differs from the previous sample, the counter shall reload with 1; otherwise it shall increment.
REQ-017 When the count reaches STABLE_CYCLES, the decoded nibble and its error bit shall be written to the digit-k slot, digit k shall be marked seen, and the FSM shall enter HELD.
REQ-018 HELD: the FSM shall stay until an changes, then re-enter SETTLE (new one-hot value) or IDLE (otherwise); LED changes in HELD are ignored.
REQ-019 Any sampled an that is not one-hot-low (all 1s, or more than one 0) shall force IDLE and discard the partial count.
REQ-020 Frame completion: the cycle after the fourth distinct digit is marked seen, the working slots shall be copied to the output frame, all seen marks shall clear, and valid shall assert.
REQ-021 A digit captured again before the frame completes shall overwrite its slot, keeping the latest value.
REQ-022 valid shall stay 1 until a handshake occurs; on the handshake cycle valid shall fall unless a new frame completes in that same cycle, in which case the new frame is loaded and valid remains 1.
REQ-023 A frame that completes while valid=1 and ready=0 shall be dropped (the output frame holds the older data), and overrun shall set.
REQ-024 overrun shall clear only on a handshake; if a drop and a handshake coincide, overrun stays set.
REQ-025 Minimum latency: the final settled digit leads to valid=1 exactly STABLE_CYCLES+2 clocks after LED/an reach the input pins.

Reset
REQ-026 While reset=0 at a clock edge: FSM=IDLE, counter=0, seen marks=0, working slots=0, value=16'h0000, digit_err=4'h0, valid=0, overrun=0.
REQ-027 Reset asserted mid-SETTLE or while valid=1 shall discard all partial and pending data, and no handshake shall occur on that cycle.

Structure
REQ-028 A shared package shall hold the glyph constants (16 patterns, BLANK=7'b1111111), SEG_W=7, DIGITS=4 and the FSM state enum.
REQ-029 The glyph lookup shall be one combinational sub-module, seg_glyph_decode (7-bit pattern in; nibble and illegal flag out), instantiated once on the registered LED.

Verification
REQ-030 Test 1: STABLE_CYCLES=4; scan an=1110,1101,1011,0111 with glyphs 4,3,2,1, each held 8 clocks, ready=1 -> exactly one valid pulse with value=16'h1234 and digit_err=0.
REQ-031 Test 2: hold digit 2 at 1111111 (blank) and the other digits at F -> value=16'hF0FF and digit_err=4'b0100.
REQ-032 Test 3: on digit 0, toggle LED every 3 clocks with STABLE_CYCLES=4 -> digit 0 is never captured and valid never asserts.
REQ-033 Test 4: hold ready=0 and run two full scans (first 16'hABCD, second 16'h0000) -> value stays 16'hABCD and overrun=1; then pulse ready=1 -> valid falls and overrun clears.
REQ-034 Test 5: drive an=1100 and an=1111 between valid digits -> the FSM enters IDLE, and the frame completes only after all four one-hot digits settle.
REQ-035 Test 6: assert reset for 1 clock during SETTLE of the third digit -> all outputs are zero, and the next full scan of 16'h5678 yields value=16'h5678 with no stale digits.
